adder16_share_arb: RTL and testbench

//  Round-robin arbiter/sequencer sharing one 16-bit ripple adder (Adder16) among NREQ requesters.

---
 rtl/adder16_share_arb_if.sv | 26 ++
 rtl/adder16_share_arb.sv | 172 +++++++++++++++++
 tb/tb_adder16_share_arb.sv | 268 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/adder16_share_arb_if.sv
// Handshake bundle for adder16_share_arb: NREQ operand channels in, one id-tagged result out.
// The arbiter takes the slave modport; client/consumer logic (or a bench) takes the master modport.
interface adder16_share_arb_if #(
  parameter int NREQ = 4,
  parameter int IDW  = 2
);
  logic [NREQ-1:0]    req_valid;
  logic [NREQ-1:0]    req_ready;
  logic [16*NREQ-1:0] req_a;
  logic [16*NREQ-1:0] req_b;
  logic               rsp_valid;
  logic               rsp_ready;
  logic [IDW-1:0]     rsp_id;
  logic [15:0]        rsp_sum;
  logic               rsp_ovfl;

  modport master (
    output req_valid, req_a, req_b, rsp_ready,
    input  req_ready, rsp_valid, rsp_id, rsp_sum, rsp_ovfl
  );

  modport slave (
    input  req_valid, req_a, req_b, rsp_ready,
    output req_ready, rsp_valid, rsp_id, rsp_sum, rsp_ovfl
  );
endinterface

// File: rtl/adder16_share_arb.sv
// Round-robin sequencer sharing one 16-bit ripple adder among NREQ requesters, one op in flight.
// Optional macro ADDER16_ARB_SAT_EN: saturate rsp_sum to 16'hFFFF on carry-out.
module adder16_share_arb #(
  parameter int NREQ = 4,
  parameter int IDW  = 2
) (
  input logic                clk,
  input logic                rst_n,
  adder16_share_arb_if.slave bus
);

  localparam int DATA_W = 16;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    RESP = 2'd2
  } state_e;

  state_e              state_q, state_d;
  logic [IDW-1:0]      rr_ptr_q, rr_ptr_d;
  logic [DATA_W-1:0]   op_a_q, op_a_d;
  logic [DATA_W-1:0]   op_b_q, op_b_d;
  logic [IDW-1:0]      op_id_q, op_id_d;
  logic                rsp_valid_q, rsp_valid_d;
  logic [IDW-1:0]      rsp_id_q, rsp_id_d;
  logic [DATA_W-1:0]   rsp_sum_q, rsp_sum_d;
  logic                rsp_ovfl_q, rsp_ovfl_d;

  logic [IDW-1:0]      grant_id;
  logic                any_valid;
  logic [NREQ-1:0]     req_ready;
  logic [DATA_W-1:0]   sel_a, sel_b;
  logic [DATA_W:0]     sum_full;

  function automatic logic [IDW-1:0] rr_idx(input logic [IDW-1:0] base, input int k);
    int s;
    s = int'(base) + k;
    if (s >= NREQ) s = s - NREQ;
    return IDW'(s);
  endfunction

  // The shared Adder16: explicit full-adder chain, carry out in the MSB of the result.
  function automatic logic [DATA_W:0] ripple_add(input logic [DATA_W-1:0] a,
                                                  input logic [DATA_W-1:0] b);
    logic [DATA_W:0]   c;
    logic [DATA_W-1:0] s;
    c[0] = 1'b0;
    for (int i = 0; i < DATA_W; i++) begin
      s[i]   = a[i] ^ b[i] ^ c[i];
      c[i+1] = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
    end
    return {c[DATA_W], s};
  endfunction

`ifdef ADDER16_ARB_SAT_EN
  function automatic logic [DATA_W-1:0] sat_sum(input logic [DATA_W-1:0] s, input logic co);
    return co ? {DATA_W{1'b1}} : s;
  endfunction
`endif

  // Walk downward so the requester closest to rr_ptr (smallest offset) wins.
  always_comb begin
    grant_id  = '0;
    any_valid = 1'b0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      if (bus.req_valid[rr_idx(rr_ptr_q, k)]) begin
        grant_id  = rr_idx(rr_ptr_q, k);
        any_valid = 1'b1;
      end
    end
  end

  always_comb begin
    sel_a = '0;
    sel_b = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (grant_id == IDW'(i)) begin
        sel_a = bus.req_a[DATA_W*i +: DATA_W];
        sel_b = bus.req_b[DATA_W*i +: DATA_W];
      end
    end
  end

  assign sum_full = ripple_add(op_a_q, op_b_q);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (any_valid) state_d = CALC;
      CALC:    state_d = RESP;
      RESP:    if (bus.rsp_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Grant is offered only while idle and out of reset; a transfer is implied by any_valid there.
  always_comb begin
    req_ready = '0;
    if (rst_n && state_q == IDLE && any_valid) req_ready[grant_id] = 1'b1;
  end

  always_comb begin
    rr_ptr_d    = rr_ptr_q;
    op_a_d      = op_a_q;
    op_b_d      = op_b_q;
    op_id_d     = op_id_q;
    rsp_valid_d = rsp_valid_q;
    rsp_id_d    = rsp_id_q;
    rsp_sum_d   = rsp_sum_q;
    rsp_ovfl_d  = rsp_ovfl_q;
    unique case (state_q)
      IDLE: begin
        if (any_valid) begin
          op_a_d   = sel_a;
          op_b_d   = sel_b;
          op_id_d  = grant_id;
          rr_ptr_d = rr_idx(grant_id, 1);
        end
      end
      CALC: begin
`ifdef ADDER16_ARB_SAT_EN
        rsp_sum_d = sat_sum(sum_full[DATA_W-1:0], sum_full[DATA_W]);
`else
        rsp_sum_d = sum_full[DATA_W-1:0];
`endif
        rsp_ovfl_d  = sum_full[DATA_W];
        rsp_id_d    = op_id_q;
        rsp_valid_d = 1'b1;
      end
      RESP: begin
        if (bus.rsp_ready) rsp_valid_d = 1'b0;
      end
      default: ;
    endcase
  end

  // Operand / response stage boundary
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_ptr_q    <= '0;
      op_a_q      <= '0;
      op_b_q      <= '0;
      op_id_q     <= '0;
      rsp_valid_q <= 1'b0;
      rsp_id_q    <= '0;
      rsp_sum_q   <= '0;
      rsp_ovfl_q  <= 1'b0;
    end else begin
      rr_ptr_q    <= rr_ptr_d;
      op_a_q      <= op_a_d;
      op_b_q      <= op_b_d;
      op_id_q     <= op_id_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_id_q    <= rsp_id_d;
      rsp_sum_q   <= rsp_sum_d;
      rsp_ovfl_q  <= rsp_ovfl_d;
    end
  end

  assign bus.req_ready = req_ready;
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_id    = rsp_id_q;
  assign bus.rsp_sum   = rsp_sum_q;
  assign bus.rsp_ovfl  = rsp_ovfl_q;

endmodule

// File: tb/tb_adder16_share_arb.sv
// Scoreboard bench for adder16_share_arb: directed corner transactions plus randomized traffic,
// checked against a round-robin / 17-bit-sum reference model.
module tb_adder16_share_arb;
  localparam int NREQ = 4;
  localparam int IDW  = 2;

  typedef struct {
    logic [IDW-1:0] id;
    logic [15:0]    sum;
    logic           ovfl;
    int             cyc;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n;
  int   cyc = 0;
  int   n_chk = 0;
  int   n_pass = 0;
  exp_t sb[$];

  adder16_share_arb_if #(.NREQ(NREQ), .IDW(IDW)) bus ();

  adder16_share_arb #(.NREQ(NREQ), .IDW(IDW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic void chk(string nm, logic [31:0] act, logic [31:0] req);
    n_chk++;
    if (act === req) n_pass++;
    else $display("FAIL %s: actual %0h required %0h (t=%0t)", nm, act, req, $time);
  endfunction

  function automatic exp_t model(int id, logic [15:0] a, logic [15:0] b, int c);
    exp_t        e;
    logic [16:0] full;
    full   = {1'b0, a} + {1'b0, b};
    e.id   = IDW'(id);
    e.ovfl = full[16];
    e.sum  = full[15:0];
`ifdef ADDER16_ARB_SAT_EN
    if (full[16]) e.sum = 16'hFFFF;
`endif
    e.cyc  = c;
    return e;
  endfunction

  // Request-side reference: round-robin pointer and busy flag, one transaction at a time.
  int              m_ptr = 0;
  bit              m_busy = 0;
  int              m_g;
  logic [NREQ-1:0] exp_rdy;

  always @(negedge clk) begin
    if (!rst_n) begin
      m_ptr  = 0;
      m_busy = 0;
      sb.delete();
    end else begin
      m_g = -1;
      if (!m_busy)
        for (int k = 0; k < NREQ; k++)
          if (m_g < 0 && bus.req_valid[(m_ptr + k) % NREQ]) m_g = (m_ptr + k) % NREQ;
      exp_rdy = (m_g >= 0) ? NREQ'(1 << m_g) : '0;
      chk("req_ready", bus.req_ready, exp_rdy);
      if (m_g >= 0) begin
        sb.push_back(model(m_g, bus.req_a[16*m_g +: 16], bus.req_b[16*m_g +: 16], cyc));
        m_ptr  = (m_g + 1) % NREQ;
        m_busy = 1;
      end else if (m_busy && bus.rsp_valid && bus.rsp_ready) begin
        m_busy = 0;
      end
    end
  end

  // Response monitor: latency on rise, stability under backpressure, pop and compare on transfer.
  bit             pv = 0, pr = 0;
  logic [IDW-1:0] pid;
  logic [15:0]    psum;
  logic           povf;
  exp_t           e;

  always @(negedge clk) begin
    if (!rst_n) begin
      pv = 0;
    end else begin
      if (bus.rsp_valid && !pv) begin
        if (sb.size() == 0) chk("rsp_unexpected", 1, 0);
        else chk("latency", cyc - sb[0].cyc, 2);
      end
      if (bus.rsp_valid && pv && !pr) begin
        chk("hold_id", bus.rsp_id, pid);
        chk("hold_sum", bus.rsp_sum, psum);
        chk("hold_ovfl", bus.rsp_ovfl, povf);
      end
      if (bus.rsp_valid && bus.rsp_ready && sb.size() > 0) begin
        e = sb.pop_front();
        chk("rsp_id", bus.rsp_id, e.id);
        chk("rsp_sum", bus.rsp_sum, e.sum);
        chk("rsp_ovfl", bus.rsp_ovfl, e.ovfl);
      end
      pv   = bus.rsp_valid;
      pr   = bus.rsp_ready;
      pid  = bus.rsp_id;
      psum = bus.rsp_sum;
      povf = bus.rsp_ovfl;
    end
  end

  task automatic put(int i, logic [15:0] a, logic [15:0] b);
    bus.req_a[16*i +: 16] = a;
    bus.req_b[16*i +: 16] = b;
  endtask

  task automatic idle(int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wait_accept(output logic [NREQ-1:0] g);
    g = '0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (|(bus.req_ready & bus.req_valid)) begin
        g = bus.req_ready;
        return;
      end
    end
    chk("accept_timeout", 0, 1);
  endtask

  task automatic single(int id, logic [15:0] a, logic [15:0] b);
    logic [NREQ-1:0] g;
    put(id, a, b);
    bus.req_valid = NREQ'(1 << id);
    wait_accept(g);
    chk("single_grant", g, 1 << id);
    @(posedge clk); #1;
    bus.req_valid = '0;
    idle(3);
  endtask

  function automatic logic [15:0] rnd_op();
    case ($urandom_range(0, 5))
      0:       return 16'hFFFF;
      1:       return 16'h0000;
      2:       return 16'h8000;
      default: return 16'($urandom);
    endcase
  endfunction

  task automatic chk_zero(string tag);
    chk({tag, "_req_ready"}, bus.req_ready, 0);
    chk({tag, "_rsp_valid"}, bus.rsp_valid, 0);
    chk({tag, "_rsp_id"},    bus.rsp_id, 0);
    chk({tag, "_rsp_sum"},   bus.rsp_sum, 0);
    chk({tag, "_rsp_ovfl"},  bus.rsp_ovfl, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: actual timeout required finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [NREQ-1:0] g;
    rst_n         = 1'b0;
    bus.req_valid = '0;
    bus.req_a     = '0;
    bus.req_b     = '0;
    bus.rsp_ready = 1'b1;
    #1;
    chk_zero("por");
    idle(3);
    rst_n = 1'b1;
    idle(2);

    // Single transaction on requester 1 with a direct look at the response two cycles later.
    put(1, 16'h1234, 16'h0FF0);
    bus.req_valid = 4'b0010;
    wait_accept(g);
    chk("t2_grant", g, 4'b0010);
    @(posedge clk); #1;
    bus.req_valid = '0;
    @(negedge clk);
    chk("t2_calc_valid", bus.rsp_valid, 0);
    @(negedge clk);
    chk("t2_rsp_valid", bus.rsp_valid, 1);
    chk("t2_rsp_id", bus.rsp_id, 1);
    chk("t2_rsp_sum", bus.rsp_sum, 16'h2224);
    chk("t2_rsp_ovfl", bus.rsp_ovfl, 0);
    idle(3);

    // Asynchronous reset while a transaction is in CALC.
    put(2, 16'h1111, 16'h2222);
    bus.req_valid = 4'b0100;
    wait_accept(g);
    @(posedge clk); #2;
    rst_n = 1'b0;
    #1;
    chk_zero("midrst");
    @(negedge clk);
    bus.req_valid = '0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    idle(4);
    chk("midrst_no_rsp", bus.rsp_valid, 0);

    // All requesters valid: strict rotation starting from 0.
    for (int i = 0; i < NREQ; i++) put(i, rnd_op(), rnd_op());
    bus.req_valid = '1;
    for (int k = 0; k < 5; k++) begin
      wait_accept(g);
      chk("rr_order", g, 1 << (k % NREQ));
      @(posedge clk); #1;
    end
    bus.req_valid = '0;
    idle(3);

    single(3, 16'hFFFF, 16'h0002);
    single(0, 16'h0FFF, 16'h0001);
    single(2, 16'h8000, 16'h8000);

    // Backpressure with every requester waiting.
    bus.rsp_ready = 1'b0;
    bus.req_valid = '1;
    wait_accept(g);
    @(posedge clk); #1;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      if (bus.rsp_valid) break;
    end
    chk("bp_rsp_valid", bus.rsp_valid, 1);
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      chk("bp_no_grant", bus.req_ready, 0);
      chk("bp_valid_held", bus.rsp_valid, 1);
    end
    @(posedge clk); #1;
    bus.rsp_ready = 1'b1;
    @(negedge clk);
    @(negedge clk);
    chk("bp_regrant", |bus.req_ready, 1);
    @(posedge clk); #1;
    bus.req_valid = '0;
    idle(4);

    // Randomized traffic with random consumer stalls.
    for (int t = 0; t < 400; t++) begin
      for (int i = 0; i < NREQ; i++) put(i, rnd_op(), rnd_op());
      bus.req_valid = NREQ'($urandom);
      bus.rsp_ready = ($urandom_range(0, 3) != 0);
      idle(1);
    end
    bus.req_valid = '0;
    bus.rsp_ready = 1'b1;
    idle(8);
    chk("sb_drained", sb.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
